page_switch_ctrl: RTL and testbench

// - Avalon-MM master that sequences page changes in the page-selector register block.
// - Accepts a page request and writes PAGE_NUM (0x10), then reads it back and compares.
// - Retries on mismatch or timeout; reports done/error.
// - Sits between system control logic and the page-selector slave port; the only writer of PAGE_NUM.

---
 rtl/page_regs_pkg.sv | 20 ++
 rtl/avmm_if.sv | 34 +++
 rtl/ps_timeout_timer.sv | 47 ++++
 rtl/page_switch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_page_switch_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/page_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : page_regs_pkg
// Purpose  : Register map shared by the page-selector slave and the
//            page_switch_ctrl master that sequences page changes.
// Contents : regs_t - byte offsets of the page-selector registers.
// Revision : 1.0 - initial release
// ============================================================================
package page_regs_pkg;

    typedef enum logic [7:0] {
        SR       = 8'h00,
        CR       = 8'h04,
        CR_S     = 8'h08,
        CR_C     = 8'h0C,
        PAGE_NUM = 8'h10
    } regs_t;

endpackage
`default_nettype wire

// File: rtl/avmm_if.sv
`default_nettype none
// ============================================================================
// Module   : avmm_if
// Purpose  : Single-beat Avalon-MM bundle.
// Ports    : master - drives address/read/write/writedata/burstcount,
//                     receives waitrequest/readdata/readdatavalid.
//            slave  - the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface avmm_if #(
    parameter int AW  = 16,
    parameter int DW  = 64,
    parameter int BCW = 4
);
    logic [AW-1:0]  address;
    logic           read;
    logic           write;
    logic [DW-1:0]  writedata;
    logic [BCW-1:0] burstcount;
    logic           waitrequest;
    logic [DW-1:0]  readdata;
    logic           readdatavalid;

    modport master (
        output address, read, write, writedata, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/ps_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module   : ps_timeout_timer
// Purpose  : Read-response watchdog. Counts enabled cycles after a clear and
//            flags expiry once the count reaches TIMEOUT-1.
// Ports    : clk, rst (async, active-high)
//            clr     - restart count at zero (wins over en)
//            en      - count this cycle
//            expired - count has reached TIMEOUT-1 (holds until clr)
// Revision : 1.0 - initial release
// ============================================================================
module ps_timeout_timer #(
    parameter  int TIMEOUT = 16,
    localparam int TW      = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired = (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            // Saturate at the expiry value so expired stays asserted.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/page_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : page_switch_ctrl
// Purpose  : Avalon-MM master that changes the active page of the
//            page-selector block: writes PAGE_NUM, reads it back, compares,
//            and retries on mismatch or read timeout.
// Ports    : clock, reset     - single clock, async active-high reset
//            req, req_page    - page-change request (sampled in IDLE only)
//            busy             - request in progress
//            done             - one-cycle pulse, page verified
//            error            - sticky, retries exhausted; cleared on accept
//            cur_page         - last verified page
//            bus              - avmm_if master port
// Revision : 1.0 - initial release
// ============================================================================
module page_switch_ctrl
    import page_regs_pkg::*;
#(
    parameter int            AW         = 16,
    parameter int            DW         = 64,
    parameter int            BCW        = 4,
    parameter int            PAGE_COUNT = 4,
    parameter int            PCW        = $clog2(PAGE_COUNT),
    parameter logic [AW-1:0] PAGE_ADDR  = AW'(PAGE_NUM),
    parameter int            MAX_RETRY  = 2,
    parameter int            TIMEOUT    = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req,
    input  logic [PCW-1:0] req_page,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [PCW-1:0] cur_page,
    avmm_if.master         bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_RWAIT = 3'd3,
        S_FAIL  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t         state_q,     state_d;
    logic [PCW-1:0] tgt_q,       tgt_d;
    logic [2:0]     retry_q,     retry_d;
    logic           busy_q,      busy_d;
    logic           error_q,     error_d;
    logic [PCW-1:0] cur_page_q,  cur_page_d;
    logic [AW-1:0]  address_q,   address_d;
    logic [DW-1:0]  writedata_q, writedata_d;

    logic w_timer_clr;
    logic w_timer_en;
    logic w_timer_expired;
    logic w_rd_match;
    logic w_unused;

    // Only the page field of the read-back word is meaningful.
    assign w_rd_match = (bus.readdata[PCW-1:0] == tgt_q);
    assign w_unused   = ^{bus.readdata[DW-1:PCW]};

    ps_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clock),
        .rst     (reset),
        .clr     (w_timer_clr),
        .en      (w_timer_en),
        .expired (w_timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        retry_d     = retry_q;
        busy_d      = busy_q;
        error_d     = error_q;
        cur_page_d  = cur_page_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    tgt_d       = req_page;
                    retry_d     = '0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    address_d   = PAGE_ADDR;
                    writedata_d = DW'(req_page);
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                if (!bus.waitrequest) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (!bus.waitrequest) begin
                    w_timer_clr = 1'b1;
                    state_d     = S_RWAIT;
                end
            end
            S_RWAIT: begin
                w_timer_en = 1'b1;
                // A response on the expiry cycle is still compared.
                if (bus.readdatavalid) begin
                    state_d = w_rd_match ? S_DONE : S_FAIL;
                end else if (w_timer_expired) begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (retry_q < 3'(MAX_RETRY)) begin
                    retry_d = retry_q + 3'd1;
                    state_d = S_WR;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_DONE: begin
                cur_page_d = tgt_q;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            S_ERROR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tgt_q       <= '0;
            retry_q     <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            cur_page_q  <= '0;
            address_q   <= '0;
            writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            retry_q     <= retry_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            cur_page_q  <= cur_page_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
        end
    end

    // Strobes decode straight from the state register so an async reset
    // removes them in the same cycle; WR and RD are exclusive states.
    assign bus.write      = (state_q == S_WR);
    assign bus.read       = (state_q == S_RD);
    assign bus.address    = address_q;
    assign bus.writedata  = writedata_q;
    assign bus.burstcount = BCW'(1);

    assign busy     = busy_q;
    assign done     = (state_q == S_DONE);
    assign error    = error_q;
    assign cur_page = cur_page_q;

endmodule
`default_nettype wire

// File: tb/tb_page_switch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_page_switch_ctrl
// Purpose  : Directed self-checking bench for page_switch_ctrl with a
//            page-selector slave model (configurable stall, latency, data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_page_switch_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 64;
    localparam int BCW = 4;
    localparam int PCW = 2;

    logic           clock    = 1'b0;
    logic           reset    = 1'b1;
    logic           req      = 1'b0;
    logic [PCW-1:0] req_page = '0;
    logic           busy;
    logic           done;
    logic           error;
    logic [PCW-1:0] cur_page;

    avmm_if #(.AW(AW), .DW(DW), .BCW(BCW)) bus ();

    page_switch_ctrl #(
        .AW(AW), .DW(DW), .BCW(BCW), .PAGE_COUNT(4),
        .MAX_RETRY(2), .TIMEOUT(16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_page (req_page),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cur_page (cur_page),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- slave model state / configuration ----------------
    int             wr_stall = 0, rd_stall = 0, bad_left = 0, lat = 0, dly = 0;
    logic [PCW-1:0] bad_val  = '0;
    bit             novalid  = 1'b0, pend = 1'b0, pw = 1'b0, pr = 1'b0;
    logic [DW-1:0]  page_reg = '0, p_wd = '0, last_wd = '0;
    logic [AW-1:0]  p_addr   = '0, last_addr = '0;
    int             wr_cnt = 0, rd_cnt = 0, done_cnt = 0, viol = 0, stall_cnt = 0;
    int             done_cyc = 0, req_cyc = 0;
    int             wr_cyc [16];
    int             rd_cyc [16];

    int tests = 0;
    int fails = 0;

    // Slave decisions are made on the falling edge for the following rising edge.
    always @(negedge clock) begin
        if (reset) begin
            bus.waitrequest   = 1'b0;
            bus.readdatavalid = 1'b0;
            bus.readdata      = '0;
            pend = 1'b0; pw = 1'b0; pr = 1'b0;
        end else begin
            bus.readdatavalid = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    pend = 1'b0;
                    bus.readdatavalid = 1'b1;
                    if (bad_left > 0) begin
                        bus.readdata = DW'(bad_val);
                        bad_left--;
                    end else begin
                        bus.readdata = page_reg;
                    end
                end else begin
                    dly--;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.read && bus.write) viol++;
            if (pw && (!bus.write || bus.address != p_addr || bus.writedata != p_wd)) viol++;
            if (pr && (!bus.read || bus.address != p_addr)) viol++;
            pw = 1'b0;
            pr = 1'b0;
            bus.waitrequest = 1'b0;
            if (bus.write) begin
                if (wr_stall > 0) begin
                    wr_stall--; stall_cnt++;
                    bus.waitrequest = 1'b1;
                    pw = 1'b1; p_addr = bus.address; p_wd = bus.writedata;
                end else begin
                    page_reg  = bus.writedata;
                    last_wd   = bus.writedata;
                    last_addr = bus.address;
                    if (wr_cnt < 16) wr_cyc[wr_cnt] = cyc;
                    wr_cnt++;
                end
            end else if (bus.read) begin
                if (rd_stall > 0) begin
                    rd_stall--; stall_cnt++;
                    bus.waitrequest = 1'b1;
                    pr = 1'b1; p_addr = bus.address;
                end else begin
                    if (rd_cnt < 16) rd_cyc[rd_cnt] = cyc;
                    rd_cnt++;
                    if (!novalid) begin
                        pend = 1'b1;
                        dly  = lat;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic cfg(input int bl, input logic [PCW-1:0] bv, input bit nv,
                       input int l, input int ws, input int rs);
        bad_left = bl; bad_val = bv; novalid = nv; lat = l;
        wr_stall = ws; rd_stall = rs;
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; viol = 0; stall_cnt = 0;
    endtask

    task automatic do_req(input logic [PCW-1:0] page);
        step();
        req = 1'b1; req_page = page; req_cyc = cyc;
        step();
        req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        check(tag, busy, 0);
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cur_page", cur_page, 0);
        check("rst_read", bus.read, 0);
        check("rst_write", bus.write, 0);
        check("rst_address", bus.address, 0);
        check("rst_writedata", bus.writedata, 0);
        check("rst_burstcount", bus.burstcount, 1);
        reset = 1'b0;
        step(); step();
        check("idle_busy", busy, 0);

        // Nominal switch to page 2
        cfg(0, 0, 0, 0, 0, 0);
        do_req(2);
        check("nom_busy_after_accept", busy, 1);
        check("nom_address", bus.address, 'h10);
        check("nom_burstcount", bus.burstcount, 1);
        wait_idle("nom_idle", 50);
        check("nom_writes", wr_cnt, 1);
        check("nom_reads", rd_cnt, 1);
        check("nom_wdata", last_wd, 2);
        check("nom_waddr", last_addr, 'h10);
        check("nom_done_pulses", done_cnt, 1);
        check("nom_latency", done_cyc - req_cyc, 4);
        check("nom_rd_after_wr", rd_cyc[0] - wr_cyc[0], 1);
        check("nom_cur_page", cur_page, 2);
        check("nom_error", error, 0);

        // Exhaustion: slave always answers 1
        cfg(1000, 1, 0, 0, 0, 0);
        do_req(3);
        wait_idle("exh_idle", 100);
        check("exh_writes", wr_cnt, 3);
        check("exh_reads", rd_cnt, 3);
        check("exh_done_pulses", done_cnt, 0);
        check("exh_error", error, 1);
        check("exh_cur_page", cur_page, 2);
        repeat (5) step();
        check("exh_error_sticky", error, 1);

        // Mismatch twice then good; accept clears the sticky error
        cfg(2, 0, 0, 0, 0, 0);
        do_req(3);
        check("mis_error_cleared", error, 0);
        wait_idle("mis_idle", 100);
        check("mis_writes", wr_cnt, 3);
        check("mis_reads", rd_cnt, 3);
        check("mis_done_pulses", done_cnt, 1);
        check("mis_cur_page", cur_page, 3);
        check("mis_error", error, 0);

        // Timeout: no response ever
        cfg(0, 0, 1, 0, 0, 0);
        do_req(1);
        wait_idle("tmo_idle", 200);
        check("tmo_writes", wr_cnt, 3);
        check("tmo_reads", rd_cnt, 3);
        check("tmo_retry_gap", wr_cyc[1] - rd_cyc[0], 18);
        check("tmo_retry_gap2", wr_cyc[2] - rd_cyc[1], 18);
        check("tmo_error", error, 1);
        check("tmo_done_pulses", done_cnt, 0);
        check("tmo_cur_page", cur_page, 3);

        // Response on the last timeout cycle is compared
        cfg(0, 0, 0, 15, 0, 0);
        do_req(1);
        wait_idle("lat15_idle", 100);
        check("lat15_writes", wr_cnt, 1);
        check("lat15_done_pulses", done_cnt, 1);
        check("lat15_cur_page", cur_page, 1);
        check("lat15_error", error, 0);

        // One cycle later is a timeout; the late response lands as a stray
        cfg(0, 0, 0, 16, 0, 0);
        do_req(2);
        wait_idle("lat16_idle", 200);
        check("lat16_writes", wr_cnt, 3);
        check("lat16_reads", rd_cnt, 3);
        check("lat16_done_pulses", done_cnt, 0);
        check("lat16_error", error, 1);
        check("lat16_cur_page", cur_page, 1);

        // req held high: not taken while DONE, taken on the next IDLE cycle
        cfg(0, 0, 0, 0, 0, 0);
        step();
        req = 1'b1; req_page = 0;
        for (int i = 0; i < 20 && !done; i++) step();
        check("b2b_done_seen", done, 1);
        check("b2b_busy_in_done", busy, 1);
        step();
        check("b2b_idle_gap", busy, 0);
        step();
        check("b2b_reaccept", busy, 1);
        req = 1'b0;
        wait_idle("b2b_idle", 50);
        check("b2b_writes", wr_cnt, 2);
        check("b2b_done_pulses", done_cnt, 2);
        check("b2b_cur_page", cur_page, 0);

        // Backpressure on both phases, plus a request while busy
        cfg(0, 0, 0, 0, 5, 5);
        do_req(2);
        req = 1'b1; req_page = 3;
        repeat (3) step();
        req = 1'b0;
        wait_idle("bp_idle", 100);
        repeat (5) step();
        check("bp_stall_cycles", stall_cnt, 10);
        check("bp_stability", viol, 0);
        check("bp_writes", wr_cnt, 1);
        check("bp_reads", rd_cnt, 1);
        check("bp_wdata", last_wd, 2);
        check("bp_done_pulses", done_cnt, 1);
        check("bp_latency", done_cyc - req_cyc, 14);
        check("bp_cur_page", cur_page, 2);

        // Reset while waiting for read data
        cfg(0, 0, 1, 0, 0, 0);
        do_req(3);
        for (int i = 0; i < 10 && rd_cnt == 0; i++) step();
        step(); step();
        check("rst_mid_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_read", bus.read, 0);
        check("rst_mid_write", bus.write, 0);
        check("rst_mid_cur_page", cur_page, 0);
        check("rst_mid_address", bus.address, 0);
        step(); step();
        reset = 1'b0;
        repeat (40) step();
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_no_restart", wr_cnt, 1);
        check("rst_mid_idle", busy, 0);

        // Reset while a write is stalled drops write immediately
        cfg(0, 0, 0, 0, 100, 0);
        do_req(1);
        check("rst_wr_write_before", bus.write, 1);
        reset = 1'b1;
        #1;
        check("rst_wr_write", bus.write, 0);
        check("rst_wr_busy", busy, 0);
        step();
        reset = 1'b0;
        cfg(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("rst_wr_viol", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
